// File: rtl/sevenseg_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_pkg
// Shared types, constants and the hex-to-segment decode used by the
// 4-digit 7-segment scanner.
//   digit_idx_t : index of the digit currently being driven (0 = rightmost)
//   SEG_BLANK   : all segments off (active-low pattern)
//   AN_OFF      : all anodes off (active-low pattern)
//   hex_to_seg  : nibble -> {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
package sevenseg_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Lower-case b and d keep 6/8 and B/8 and D/0 distinguishable on the display.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] pattern;
    case (hex)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h10;
      4'hA:    pattern = 7'h08;
      4'hB:    pattern = 7'h03;
      4'hC:    pattern = 7'h46;
      4'hD:    pattern = 7'h21;
      4'hE:    pattern = 7'h06;
      default: pattern = 7'h0E;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/sevenseg_scanner_refresh_tick_gen.sv
// -----------------------------------------------------------------------------
// refresh_tick_gen
// Free-running prescaler that sets how long each digit stays lit.
// Counts 0..REFRESH_DIV-1 and wraps.
//   clk     in  system clock
//   reset   in  synchronous, active-high
//   tick    out high during the last cycle of a slot (count == REFRESH_DIV-1)
//   at_zero out high during the first cycle of a slot (count == 0)
// -----------------------------------------------------------------------------
module refresh_tick_gen #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic at_zero
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] count;

  assign tick    = (count == LAST);
  assign at_zero = (count == '0);

  // Wrap on tick rather than on overflow so non-power-of-two dividers
  // still give slots of exactly REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/sevenseg_scanner.sv
// -----------------------------------------------------------------------------
// sevenseg_scanner
// Time-multiplexes four nibbles onto a 4-digit common-anode 7-segment display.
// Inputs are captured into a frame buffer once per frame (start of slot 0) so
// a frame never mixes old and new data. One digit is lit at a time.
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   value    in   16  digit i shows value[4i+3:4i], digit 0 rightmost
//   digit_en in   4   1 = digit i displayed, 0 = blanked
//   dp       in   4   1 = decimal point of digit i lit
//   an       out  4   anode enables, active-low (one low or all high)
//   seg      out  7   {g,f,e,d,c,b,a}, active-low
//   dp_n     out  1   decimal point, active-low
// -----------------------------------------------------------------------------
module sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n
);

  logic       tick;
  logic       at_zero;
  digit_idx_t idx;

  logic [15:0] shadow_value;
  logic [3:0]  shadow_en;
  logic [3:0]  shadow_dp;

  logic [3:0]  an_next;
  logic [6:0]  seg_next;
  logic        dp_n_next;
  logic [3:0]  nibble;

  refresh_tick_gen #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .at_zero(at_zero)
  );

  assign nibble = shadow_value[{idx, 2'b00} +: 4];

  // Decode of the current slot; a disabled digit is fully dark, including
  // its decimal point.
  always_comb begin
    an_next   = AN_OFF;
    seg_next  = SEG_BLANK;
    dp_n_next = 1'b1;
    if (shadow_en[idx]) begin
      an_next   = ~(4'b0001 << idx);
      seg_next  = hex_to_seg(nibble);
      dp_n_next = ~shadow_dp[idx];
    end
  end

  // Slot index, frame buffer and registered outputs. Outputs are registered
  // so the display changes in a single clean step between slots; they show
  // the decode of idx/shadow from one cycle earlier.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx          <= '0;
      shadow_value <= '0;
      shadow_en    <= '0;
      shadow_dp    <= '0;
      an           <= AN_OFF;
      seg          <= SEG_BLANK;
      dp_n         <= 1'b1;
    end else begin
      if (tick) begin
        idx <= idx + digit_idx_t'(1);
      end
      if (idx == digit_idx_t'(0) && at_zero) begin
        shadow_value <= value;
        shadow_en    <= digit_en;
        shadow_dp    <= dp;
      end
      an   <= an_next;
      seg  <= seg_next;
      dp_n <= dp_n_next;
    end
  end

endmodule

// File: tb/tb_sevenseg_scanner.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scanner
// Self-checking bench for sevenseg_scanner with REFRESH_DIV=4 and a 10 ns
// clock. Expected outputs come from a frame-level model: the position inside
// the current 4-slot frame is derived from the number of edges since reset.
// -----------------------------------------------------------------------------
module tb_sevenseg_scanner;

  localparam int D     = 4;
  localparam int FRAME = 4 * D;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  int asserts_done = 0;
  int failures     = 0;

  // Model state: edges since reset release and the frame it latched.
  int          model_t;
  logic [15:0] m_value;
  logic [3:0]  m_en;
  logic [3:0]  m_dp;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp_n;
  string       phase;

  logic [6:0] seg_table [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sevenseg_scanner #(.REFRESH_DIV(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .value   (value),
    .digit_en(digit_en),
    .dp      (dp),
    .an      (an),
    .seg     (seg),
    .dp_n    (dp_n)
  );

  always #5 clk = ~clk;

  // Expected display after the current edge, from the inputs sampled there.
  task automatic modelEdge();
    int pos;
    int slot;
    if (reset) begin
      exp_an   = 4'b1111;
      exp_seg  = 7'h7F;
      exp_dp_n = 1'b1;
      model_t  = 0;
      m_value  = '0;
      m_en     = '0;
      m_dp     = '0;
    end else begin
      pos  = model_t % FRAME;
      slot = pos / D;
      exp_an   = 4'b1111;
      exp_seg  = 7'h7F;
      exp_dp_n = 1'b1;
      if (m_en[slot]) begin
        exp_an[slot] = 1'b0;
        exp_seg      = seg_table[m_value[slot*4 +: 4]];
        exp_dp_n     = ~m_dp[slot];
      end
      if (pos == 0) begin
        m_value = value;
        m_en    = digit_en;
        m_dp    = dp;
      end
      model_t++;
    end
  endtask

  task automatic checkOutput();
    asserts_done++;
    assert (an === exp_an) else begin
      failures++;
      $error("[TB] FAIL %s an t=%0d got=%b exp=%b", phase, model_t, an, exp_an);
    end
    asserts_done++;
    assert (seg === exp_seg) else begin
      failures++;
      $error("[TB] FAIL %s seg t=%0d got=%h exp=%h", phase, model_t, seg, exp_seg);
    end
    asserts_done++;
    assert (dp_n === exp_dp_n) else begin
      failures++;
      $error("[TB] FAIL %s dp_n t=%0d got=%b exp=%b", phase, model_t, dp_n, exp_dp_n);
    end
    asserts_done++;
    assert (an === 4'b1111 || $onehot(~an)) else begin
      failures++;
      $error("[TB] FAIL %s an_one_cold got=%b exp=one-cold-or-1111", phase, an);
    end
  endtask

  // Advance n clock edges, updating the model and checking after each edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput();
    end
  endtask

  task automatic waitForPos(input int target);
    for (int k = 0; k < FRAME && (model_t % FRAME) != target; k++) begin
      applyStimulus(1);
    end
    asserts_done++;
    assert ((model_t % FRAME) == target) else begin
      failures++;
      $error("[TB] FAIL %s frame_align got=%0d exp=%0d", phase, model_t % FRAME, target);
    end
  endtask

  initial begin
    reset    = 1'b1;
    value    = '0;
    digit_en = '0;
    dp       = '0;
    model_t  = 0;

    phase = "reset";
    applyStimulus(3);

    // Release: edge 1 loads the frame buffer, edge 2 lights digit 0.
    phase    = "release";
    reset    = 1'b0;
    value    = 16'h1234;
    digit_en = 4'b1111;
    dp       = 4'b0000;
    applyStimulus(1);
    asserts_done++;
    assert (an === 4'b1111 && seg === 7'h7F) else begin
      failures++;
      $error("[TB] FAIL edge1_blank got=%b/%h exp=1111/7f", an, seg);
    end
    applyStimulus(1);
    asserts_done++;
    assert (an === 4'b1110 && seg === 7'h19 && dp_n === 1'b1) else begin
      failures++;
      $error("[TB] FAIL edge2_digit0 got=%b/%h/%b exp=1110/19/1", an, seg, dp_n);
    end

    phase = "count1234";
    applyStimulus(2 * FRAME);

    // Mid-frame input change only shows up from the next frame.
    phase = "abcd";
    waitForPos(D);
    value = 16'hABCD;
    applyStimulus(2 * FRAME);

    phase    = "enables";
    digit_en = 4'b0101;
    dp       = 4'b0001;
    applyStimulus(2 * FRAME);

    phase = "reset_mid";
    waitForPos(2 * D + 1);
    reset = 1'b1;
    applyStimulus(1);
    reset    = 1'b0;
    value    = 16'(($urandom));
    digit_en = 4'b1111;
    dp       = 4'(($urandom));
    applyStimulus(FRAME + 4);

    phase = "sweep";
    dp    = 4'b0000;
    for (int v = 0; v < 16; v++) begin
      value[3:0] = 4'(v);
      applyStimulus(FRAME);
    end

    phase = "random";
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) value = 16'($urandom);
      if ($urandom_range(0, 9) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 9) == 0) dp = 4'($urandom);
      reset = ($urandom_range(0, 79) == 0);
      applyStimulus(1);
    end
    reset = 1'b0;
    applyStimulus(FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts_done, failures);
    $finish;
  end

endmodule
